// File: rtl/break_sequencer.sv
// 7-cycle RES/NMI/IRQ/BRK entry sequencer for the 6502 core.
// Define NMI_HIJACK_EN to let a pending NMI take over an IRQ/BRK sequence at its vector fetch.
module break_sequencer #(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] NMI_VEC    = 16'hFFFA,
    parameter logic [15:0] RES_VEC    = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
    input  logic        clk_1,
    input  logic        res_p,
    input  logic        rdy,
    input  logic        sync_start,
    input  logic        brk_op,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic [7:0]  sp_in,
    output logic        busy,
    output logic [2:0]  step,
    output logic [1:0]  kind,
    output logic [1:0]  addr_src,
    output logic [15:0] addr,
    output logic        rw,
    output logic [1:0]  push_sel,
    output logic        b_flag,
    output logic        sp_dec,
    output logic        set_i,
    output logic        pcl_load,
    output logic        pch_load,
    output logic        done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PC1    = 3'd1;
    localparam logic [2:0] S_PUSH_H = 3'd3;
    localparam logic [2:0] S_PUSH_L = 3'd4;
    localparam logic [2:0] S_PUSH_P = 3'd5;
    localparam logic [2:0] S_VEC_L  = 3'd6;
    localparam logic [2:0] S_VEC_H  = 3'd7;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_RES  = 2'd1;
    localparam logic [1:0] K_NMI  = 2'd2;
    localparam logic [1:0] K_IRQ  = 2'd3;

    localparam logic [1:0] SRC_STACK = 2'd1;
    localparam logic [1:0] SRC_VEC   = 2'd2;

    logic [2:0]  step_q, step_d;
    logic [1:0]  kind_q, kind_d, kind_eff;
    logic        brk_q, brk_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic        prev_nmi_q;
    logic        res_pend_q, res_pend_d;
    logic        nmi_edge, push_cyc, write_cyc, adv;
    logic [15:0] vec_lo;

    always_ff @(posedge clk_1) begin
        if (res_p) begin
            step_q     <= S_IDLE;
            kind_q     <= K_NONE;
            brk_q      <= 1'b0;
            nmi_pend_q <= 1'b0;
            prev_nmi_q <= 1'b0;
            res_pend_q <= 1'b1;
        end else begin
            step_q     <= step_d;
            kind_q     <= kind_d;
            brk_q      <= brk_d;
            nmi_pend_q <= nmi_pend_d;
            prev_nmi_q <= nmi_n;
            res_pend_q <= res_pend_d;
        end
    end

    always_comb begin
        step_d     = step_q;
        kind_d     = kind_q;
        brk_d      = brk_q;
        nmi_pend_d = nmi_pend_q;
        res_pend_d = res_pend_q;

        busy     = 1'b0;
        step     = 3'd0;
        kind     = K_NONE;
        addr_src = 2'd0;
        addr     = 16'h0000;
        rw       = 1'b1;
        push_sel = 2'd0;
        b_flag   = 1'b0;
        sp_dec   = 1'b0;
        set_i    = 1'b0;
        pcl_load = 1'b0;
        pch_load = 1'b0;
        done     = 1'b0;

        nmi_edge = prev_nmi_q & ~nmi_n;
        kind_eff = kind_q;
`ifdef NMI_HIJACK_EN
        if (step_q == S_VEC_L && kind_q == K_IRQ && nmi_pend_q)
            kind_eff = K_NMI;
`endif
        push_cyc  = (step_q == S_PUSH_H) || (step_q == S_PUSH_L) || (step_q == S_PUSH_P);
        // Reset sequence turns the pushes into reads, so they obey rdy like any read.
        write_cyc = push_cyc && (kind_q != K_RES);
        adv       = write_cyc || rdy;
        vec_lo    = (kind_eff == K_RES) ? RES_VEC : (kind_eff == K_NMI) ? NMI_VEC : IRQ_VEC;

        if (step_q == S_IDLE) begin
            if (res_pend_q) begin
                step_d     = S_PC1;
                kind_d     = K_RES;
                brk_d      = 1'b0;
                res_pend_d = 1'b0;
            end else if (sync_start) begin
                if (nmi_pend_q || nmi_edge) begin
                    step_d = S_PC1;
                    kind_d = K_NMI;
                    brk_d  = 1'b0;
                end else if (!irq_n && !i_flag) begin
                    step_d = S_PC1;
                    kind_d = K_IRQ;
                    brk_d  = 1'b0;
                end else if (brk_op) begin
                    step_d = S_PC1;
                    kind_d = K_IRQ;
                    brk_d  = 1'b1;
                end
            end
        end else begin
            if (step_q == S_VEC_L) begin
                kind_d = kind_eff;
                if (kind_eff == K_NMI)
                    nmi_pend_d = 1'b0;
            end
            if (adv)
                step_d = (step_q == S_VEC_H) ? S_IDLE : step_q + 3'd1;
        end
        // A fresh edge outranks the step-6 clear.
        if (nmi_edge)
            nmi_pend_d = 1'b1;

        if (!res_p && step_q != S_IDLE) begin
            busy = 1'b1;
            step = step_q;
            kind = kind_eff;
            case (step_q)
                S_PUSH_H, S_PUSH_L, S_PUSH_P: begin
                    addr_src = SRC_STACK;
                    addr     = {STACK_PAGE, sp_in};
                    rw       = ~write_cyc;
                    sp_dec   = adv;
                    if (step_q == S_PUSH_L)
                        push_sel = 2'd1;
                    if (step_q == S_PUSH_P) begin
                        push_sel = 2'd2;
                        b_flag   = brk_q;
                    end
                end
                S_VEC_L: begin
                    addr_src = SRC_VEC;
                    addr     = vec_lo;
                    set_i    = adv;
                    pcl_load = adv;
                end
                S_VEC_H: begin
                    addr_src = SRC_VEC;
                    addr     = vec_lo + 16'd1;
                    pch_load = adv;
                    done     = adv;
                end
                default: ;
            endcase
        end
    end

endmodule
